// File: rtl/mult8_pp_accum_if.sv
// Handshake bundle between a mult8 partition stage and the partial-product accumulator.
// ACC_W must match the ACC_W of the accumulator attached to the slave side.
interface mult8_pp_accum_if #(
    parameter int unsigned ACC_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_data;
    logic [3:0]       in_shift;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_product;
    logic             out_ovf;
    logic             out_trunc;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shift, in_last, out_ready,
        input  in_ready, out_valid, out_product, out_ovf, out_trunc, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_last, out_ready,
        output in_ready, out_valid, out_product, out_ovf, out_trunc, out_err
    );
endinterface

// File: rtl/mult8_pp_accum.sv
// Accumulates shifted partial-product beats into one product, closed by in_last or a beat
// limit, and holds the result with sticky overflow/truncation/error flags until drained.
module mult8_pp_accum #(
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned ACC_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    mult8_pp_accum_if.slave bus
);
    localparam int unsigned TermW = 19;
    localparam int unsigned CntW  = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             trunc_q, trunc_d;
    logic             err_q, err_d;
    logic             live_q, live_d;

    logic             in_ready;
    logic             accept;
    logic             first;
    logic [TermW-1:0] term;
    logic             term_hi_nz;
    logic [ACC_W-1:0] term_lo;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             beat_ovf;
    logic [CntW-1:0]  cnt_inc;
    logic             at_limit;

    // live_q keeps in_ready low during reset and until the first clock edge after release.
    assign in_ready = live_q && (state_q != StDone);
    assign accept   = bus.in_valid && in_ready;
    assign first    = (state_q == StIdle);

    always_comb begin
        term       = {8'b0, bus.in_data} << bus.in_shift[2:0];
        term_hi_nz = (term >> ACC_W) != '0;
        term_lo    = ACC_W'(term);
        base       = first ? '0 : acc_q;
        sum        = {1'b0, base} + {1'b0, term_lo};
        beat_ovf   = term_hi_nz || sum[ACC_W];
        if (first) begin
            cnt_inc = CntW'(1);
        end else if (cnt_q == CntW'(MAX_BEATS)) begin
            cnt_inc = cnt_q;
        end else begin
            cnt_inc = cnt_q + CntW'(1);
        end
        at_limit = (cnt_inc == CntW'(MAX_BEATS));
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        err_d   = err_q;
        live_d  = 1'b1;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    // A new product drops the previous result's flags before this beat's own.
                    acc_d   = sum[ACC_W-1:0];
                    cnt_d   = cnt_inc;
                    ovf_d   = beat_ovf;
                    trunc_d = 1'b0;
                    err_d   = bus.in_shift[3];
                    state_d = bus.in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q || beat_ovf;
                    err_d = err_q || bus.in_shift[3];
                    if (bus.in_last) begin
                        state_d = StDone;
                    end else if (at_limit) begin
                        state_d = StDone;
                        trunc_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == StDone);
    assign bus.out_product = acc_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_trunc   = trunc_q;
    assign bus.out_err     = err_q;

    a_no_ready_in_done: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_ready && bus.out_valid));

    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_product) && bus.out_valid);
endmodule

// File: tb/tb_mult8_pp_accum.sv
// Self-checking bench for mult8_pp_accum: directed table, multi-cycle corner sequences and
// randomized products checked against an arithmetic reference model.
module tb_mult8_pp_accum;
    localparam int unsigned AccW     = 16;
    localparam int unsigned MaxBeats = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult8_pp_accum_if #(.ACC_W(AccW)) bus ();

    mult8_pp_accum #(
        .MAX_BEATS(MaxBeats),
        .ACC_W    (AccW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int unsigned nb;
        logic [10:0] d0;
        logic [3:0]  s0;
        logic [10:0] d1;
        logic [3:0]  s1;
        logic [15:0] prod;
        logic        ovf;
        logic        trunc;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [10:0] d, input logic [3:0] s, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready before beat", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shift = s;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] p, input logic o,
                                 input logic t, input logic e, input int hold);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        repeat (hold) @(negedge clk);
        chk({tag, " product"}, 32'(bus.out_product), 32'(p));
        chk({tag, " ovf"}, 32'(bus.out_ovf), 32'(o));
        chk({tag, " trunc"}, 32'(bus.out_trunc), 32'(t));
        chk({tag, " err"}, 32'(bus.out_err), 32'(e));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid after drain"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " in_ready after drain"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic [10:0] rd;
        logic [3:0]  rs;
        logic        rl;
        longint unsigned acc, term;
        logic        m_ovf, m_trunc, m_err, done;
        int unsigned nbeat;

        tbl[0] = '{nb: 2, d0: 11'h0FF, s0: 4'd0, d1: 11'h0AB, s1: 4'd4,
                   prod: 16'h0BAF, ovf: 1'b0, trunc: 1'b0, err: 1'b0};
        tbl[1] = '{nb: 1, d0: 11'h7FF, s0: 4'd7, d1: 11'h000, s1: 4'd0,
                   prod: 16'hFF80, ovf: 1'b1, trunc: 1'b0, err: 1'b0};
        tbl[2] = '{nb: 1, d0: 11'h001, s0: 4'd9, d1: 11'h000, s1: 4'd0,
                   prod: 16'h0002, ovf: 1'b0, trunc: 1'b0, err: 1'b1};
        tbl[3] = '{nb: 2, d0: 11'h123, s0: 4'd0, d1: 11'h010, s1: 4'd8,
                   prod: 16'h0133, ovf: 1'b0, trunc: 1'b0, err: 1'b1};
        tbl[4] = '{nb: 2, d0: 11'h7FF, s0: 4'd5, d1: 11'h020, s1: 4'd0,
                   prod: 16'h0000, ovf: 1'b1, trunc: 1'b0, err: 1'b0};
        tbl[5] = '{nb: 2, d0: 11'h400, s0: 4'd7, d1: 11'h001, s1: 4'd0,
                   prod: 16'h0001, ovf: 1'b1, trunc: 1'b0, err: 1'b0};
        tbl[6] = '{nb: 1, d0: 11'h000, s0: 4'd0, d1: 11'h000, s1: 4'd0,
                   prod: 16'h0000, ovf: 1'b0, trunc: 1'b0, err: 1'b0};
        tbl[7] = '{nb: 2, d0: 11'h3FF, s0: 4'd6, d1: 11'h03F, s1: 4'd0,
                   prod: 16'hFFFF, ovf: 1'b0, trunc: 1'b0, err: 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shift  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, including across clock edges while held in reset.
        #3;
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset product", 32'(bus.out_product), 32'd0);
        chk("reset flags", 32'({bus.out_ovf, bus.out_trunc, bus.out_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready held in reset", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready after first edge", 32'(bus.in_ready), 32'd1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].nb == 2) begin
                send_beat(tbl[i].d0, tbl[i].s0, 1'b0);
                chk($sformatf("tbl%0d mid out_valid", i), 32'(bus.out_valid), 32'd0);
                send_beat(tbl[i].d1, tbl[i].s1, 1'b1);
            end else begin
                send_beat(tbl[i].d0, tbl[i].s0, 1'b1);
            end
            chk($sformatf("tbl%0d latency", i), 32'(bus.out_valid), 32'd1);
            expect_result($sformatf("tbl%0d", i), tbl[i].prod, tbl[i].ovf, tbl[i].trunc,
                          tbl[i].err, 0);
        end

        // Beat limit without in_last closes the product as truncated.
        for (int i = 0; i < 8; i++) begin
            send_beat(11'h001, 4'd0, 1'b0);
            chk($sformatf("limit beat%0d out_valid", i), 32'(bus.out_valid),
                32'(i == 7 ? 1 : 0));
        end
        expect_result("limit", 16'h0008, 1'b0, 1'b1, 1'b0, 0);

        // in_last on the limit beat is a normal close.
        for (int i = 0; i < 8; i++) begin
            send_beat(11'h001, 4'd0, (i == 7) ? 1'b1 : 1'b0);
        end
        expect_result("limit with last", 16'h0008, 1'b0, 1'b0, 1'b0, 0);

        // Backpressure: result and flags hold, offered beats are not taken.
        send_beat(11'h0FF, 4'd9, 1'b1);
        held = 16'h01FE;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 11'h7FF;
        bus.in_shift = 4'd0;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d product", i), 32'(bus.out_product), 32'(held));
            chk($sformatf("hold%0d err", i), 32'(bus.out_err), 32'd1);
            chk($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        chk("drain cycle in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("after drain out_valid", 32'(bus.out_valid), 32'd0);
        chk("after drain in_ready", 32'(bus.in_ready), 32'd1);

        // No timeout in the middle of a product.
        send_beat(11'h010, 4'd0, 1'b0);
        send_beat(11'h020, 4'd0, 1'b0);
        repeat (30) @(negedge clk);
        chk("stall out_valid", 32'(bus.out_valid), 32'd0);
        chk("stall in_ready", 32'(bus.in_ready), 32'd1);
        send_beat(11'h001, 4'd0, 1'b1);
        expect_result("stall", 16'h0031, 1'b0, 1'b0, 1'b0, 0);

        // Reset mid-product discards it and clears everything at once.
        send_beat(11'h7FF, 4'd15, 1'b0);
        send_beat(11'h005, 4'd0, 1'b0);
        send_beat(11'h005, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset product", 32'(bus.out_product), 32'd0);
        chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid reset flags", 32'({bus.out_ovf, bus.out_trunc, bus.out_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset out_valid", 32'(bus.out_valid), 32'd0);
        send_beat(11'h003, 4'd1, 1'b1);
        expect_result("post reset", 16'h0006, 1'b0, 1'b0, 1'b0, 0);

        // Randomized products against the arithmetic model.
        for (int p = 0; p < 150; p++) begin
            acc     = 0;
            m_ovf   = 1'b0;
            m_trunc = 1'b0;
            m_err   = 1'b0;
            nbeat   = 0;
            done    = 1'b0;
            while (!done) begin
                rd = 11'($urandom);
                if ($urandom_range(0, 7) == 0) rs = 4'($urandom_range(8, 15));
                else rs = 4'($urandom_range(0, 7));
                rl = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(rd, rs, rl);
                term = longint'(rd) << (rs & 4'd7);
                if (acc + term >= 64'd65536) m_ovf = 1'b1;
                acc = (acc + term) % 64'd65536;
                if (rs > 4'd7) m_err = 1'b1;
                nbeat++;
                if (rl) begin
                    done = 1'b1;
                end else if (nbeat == MaxBeats) begin
                    m_trunc = 1'b1;
                    done    = 1'b1;
                end
                chk($sformatf("rnd%0d beat%0d out_valid", p, nbeat), 32'(bus.out_valid),
                    32'(done));
            end
            expect_result($sformatf("rnd%0d", p), 16'(acc), m_ovf, m_trunc, m_err,
                          $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
